// File: rtl/blk_addr_decode.sv
// Linear cell address to (column, row) decoder for a character display.
// Uses a 7-step restoring divider by COLS with a valid/ready handshake on both sides.
module blk_addr_decode #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] blk_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  hc_addr,
  output logic [6:0]  vc_addr,
  output logic        addr_err
);

  localparam logic [13:0] LP_COLS  = 14'(COLS);
  localparam logic [13:0] LP_LIMIT = 14'(COLS * ROWS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [13:0] r_rem;
  logic [6:0]  r_q;
  logic [2:0]  r_step;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_err;

  logic [13:0] w_div_sh;
  logic        w_fit;

  // Shifted divisor for the current step; 14 bits so COLS<<6 never overflows.
  always_comb begin
    w_div_sh = LP_COLS << r_step;
    w_fit    = (r_rem >= w_div_sh);
  end

  // Control FSM and divider datapath. in_ready is held low during reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= ST_IDLE;
      r_rem       <= 14'd0;
      r_q         <= 7'd0;
      r_step      <= 3'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_in_ready && in_valid) begin
            r_rem      <= {1'b0, blk_addr};
            r_q        <= 7'd0;
            r_step     <= 3'd6;
            r_err      <= ({1'b0, blk_addr} >= LP_LIMIT);
            r_in_ready <= 1'b0;
            r_state    <= ST_CALC;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_CALC: begin
          if (w_fit) begin
            r_rem         <= r_rem - w_div_sh;
            r_q[r_step]   <= 1'b1;
          end else begin
            r_rem <= r_rem;
          end
          r_step <= r_step - 3'd1;
          if (r_step == 3'd0) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_state <= ST_CALC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign hc_addr   = r_rem[6:0];
  assign vc_addr   = r_q;
  assign addr_err  = r_err;

endmodule

// File: doc/blk_addr_decode.md
BLK_ADDR_DECODE -- requirements
Module: blk_addr_decode

Interface
REQ-001 The block SHALL have parameter COLS, default 80, meaning character cells per row; legal range 1..127.
REQ-002 The block SHALL have parameter ROWS, default 60, meaning rows on screen; COLS*ROWS SHALL be at most 8192.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 The block SHALL have port clr_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port flush  input  1  synchronous abort of any transaction in progress.
REQ-006 The block SHALL have port in_valid  input  1  blk_addr is valid.
REQ-007 The block SHALL have port in_ready  output  1  block can accept blk_addr.
REQ-008 The block SHALL have port blk_addr  input  13  linear cell address, equal to vc*COLS+hc.
REQ-009 The block SHALL have port out_valid  output  1  hc_addr, vc_addr and addr_err are valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 The block SHALL have port hc_addr  output  7  column, equal to blk_addr mod COLS.
REQ-012 The block SHALL have port vc_addr  output  7  row, equal to blk_addr div COLS.
REQ-013 The block SHALL have port addr_err  output  1  blk_addr >= COLS*ROWS.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
REQ-015 IDLE: in_ready=1 and out_valid=0.
  - On in_valid=1, the block SHALL latch rem=blk_addr, q=0, step=6 and addr_err=(blk_addr>=COLS*ROWS).
  - It SHALL then enter CALC.
REQ-016 CALC: in_ready=0 and out_valid=0. Each cycle runs one restoring-division step:
  - If rem >= (COLS<<step), then rem -= COLS<<step and q[step]=1.
  - step decrements by 1.
  - After step 0 is processed, the FSM SHALL enter DONE.
REQ-017 CALC SHALL last exactly 7 cycles.
  - With acceptance at edge E, out_valid SHALL rise after edge E+7.
REQ-018 Comparisons and subtraction SHALL use at least 14 bits, so COLS<<6 cannot overflow.
REQ-019 DONE: out_valid=1, hc_addr=rem[6:0] and vc_addr=q.
  - hc_addr, vc_addr and addr_err SHALL be held stable while out_ready=0.
REQ-020 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge.
  - in_ready SHALL NOT be asserted in DONE; back-to-back throughput is one result per 9 cycles.
REQ-021 An out-of-range address SHALL still be fully divided.
  - Example: vc_addr may exceed ROWS-1, and hc_addr SHALL stay correct.
  - addr_err=1 SHALL be reported with that result.
REQ-022 blk_addr SHALL be ignored outside the IDLE acceptance edge; input changes during CALC SHALL NOT affect the result.
REQ-023 flush=1 SHALL force IDLE on the next edge from any state and discard the transaction.
  - flush SHALL take priority over in_valid and out_ready in the same cycle; no acceptance SHALL occur that cycle.
REQ-024 blk_addr=0 SHALL produce hc=0, vc=0.
  - Addresses that are exact multiples of COLS SHALL produce hc=0.
REQ-025 The block SHALL never emit hc_addr >= COLS.

Reset
REQ-026 clr_n=0 SHALL immediately, without a clock, set the state to IDLE.
REQ-027 Asynchronous reset SHALL clear the following to 0: rem, q, step, out_valid, hc_addr, vc_addr and addr_err.
REQ-028 During reset, in_ready SHALL be 0.
  - in_ready SHALL be 1 from the first clk edge after clr_n deasserts.
REQ-029 Reset asserted mid-CALC or in DONE SHALL discard the transaction; no out_valid SHALL follow reset release without a new acceptance.

Verification
REQ-030 Corner addresses, COLS=80, ROWS=60, out_ready=1:
  - blk_addr=0 -> hc=0, vc=0, err=0.
  - blk_addr=4799 -> hc=79, vc=59, err=0, with out_valid exactly 7 cycles after acceptance.
REQ-031 Mid-range address: blk_addr=161 -> hc=1, vc=2.
  - blk_addr=80 -> hc=0, vc=1.
REQ-032 Out of range:
  - blk_addr=4800 -> hc=0, vc=60, err=1.
  - blk_addr=8191 -> hc=31, vc=102, err=1.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Outputs SHALL be stable and in_ready=0 for those cycles.
  - After out_ready=1, the FSM SHALL be in IDLE next cycle.
REQ-034 Abort:
  - Assert flush in the 3rd CALC cycle -> IDLE next cycle, no out_valid.
  - Pulse clr_n low in the 5th CALC cycle -> all outputs 0 immediately, in_ready=1 after release.
REQ-035 Random regression: 10,000 random blk_addr values with random in_valid/out_ready gaps.
  - Every result SHALL match the reference model, including addr_err.
  - No transaction SHALL be lost or duplicated.
